// File: rtl/pwm_stage_if.sv
// pwm_stage_if: duty-value handshake between a producer and pwm_stage.
//   duty_data  : new duty value offered by the producer
//   duty_valid : duty_data is valid, held until accepted
//   duty_ready : consumer's pending slot is empty, so an offer is accepted this cycle
// Modports: master = producer, slave = pwm_stage.
`timescale 1ns/1ps
interface pwm_stage_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0] duty_data;
   logic             duty_valid;
   logic             duty_ready;

   modport master (
      output duty_data,
      output duty_valid,
      input  duty_ready
   );

   modport slave (
      input  duty_data,
      input  duty_valid,
      output duty_ready
   );
endinterface

// File: rtl/pwm_stage.sv
// pwm_stage: compare-based PWM output stage driven by an external free-running
// counter, with a one-deep pending slot so duty updates only take effect at a
// period boundary (wrap).
// Ports:
//   CLK         : clock, all state updates on the rising edge
//   RESETN      : asynchronous active-low reset
//   cnt         : upstream counter value (WIDTH bits)
//   wrap        : upstream carry-out, high while cnt is at its maximum
//   duty        : pwm_stage_if.slave duty handshake (duty_ready is combinational)
//   pwm         : registered PWM output, (cnt < active) one cycle late
//   period_done : registered one-cycle pulse in the cycle after wrap
//   period_cnt  : 8-bit wrap counter, only with PWM_STAGE_PERIOD_CNT_EN defined
// Optional feature macro: PWM_STAGE_PERIOD_CNT_EN.
`timescale 1ns/1ps
module pwm_stage #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned RESET_DUTY = 0
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic [WIDTH-1:0] cnt,
   input  logic             wrap,
   pwm_stage_if.slave       duty,
   output logic             pwm,
   output logic             period_done
`ifdef PWM_STAGE_PERIOD_CNT_EN
   ,
   output logic [7:0]       period_cnt
`endif
);

   logic [WIDTH-1:0] active;
   logic [WIDTH-1:0] pending;
   logic             pending_full;
   logic             accept_c;

   // Slot empty means an offer is taken this cycle.
   assign duty.duty_ready = ~pending_full;
   assign accept_c        = duty.duty_valid & ~pending_full;

   // Duty registers: active only changes at wrap; an offer arriving in the
   // wrap cycle with an empty slot bypasses straight into active.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         active       <= WIDTH'(RESET_DUTY);
         pending      <= '0;
         pending_full <= 1'b0;
      end else if (wrap) begin
         if (pending_full) begin
            active       <= pending;
            pending_full <= 1'b0;
         end else if (accept_c) begin
            active <= duty.duty_data;
         end
      end else if (accept_c) begin
         pending      <= duty.duty_data;
         pending_full <= 1'b1;
      end
   end

   // Output flops; the compare in the wrap cycle still sees the old active.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         pwm         <= 1'b0;
         period_done <= 1'b0;
      end else begin
         pwm         <= (cnt < active);
         period_done <= wrap;
      end
   end

`ifdef PWM_STAGE_PERIOD_CNT_EN
   localparam int unsigned PCNT_W = 8;

   // Completed-period counter, wraps modulo 256.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         period_cnt <= '0;
      end else if (wrap) begin
         period_cnt <= period_cnt + PCNT_W'(1);
      end
   end
`endif

endmodule

// File: doc/pwm_stage.md
PWM_STAGE -- requirements
Module: pwm_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the width of the upstream count value and of the duty value.
REQ-002 The block SHALL have parameter RESET_DUTY, default 0, giving the active duty loaded on reset.
REQ-003 Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port RESETN, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port cnt, input, WIDTH bits: current value of the upstream free-running counter.
REQ-006 Port wrap, input, 1 bit: upstream carry-out; high in the cycle where cnt == 2^WIDTH-1, so the counter reads 0 next cycle.
REQ-007 Port duty_data, input, WIDTH bits: new duty value offered by the producer.
REQ-008 Port duty_valid, input, 1 bit: duty_data is valid.
REQ-009 Port duty_ready, output, 1 bit: the pending slot is empty, so an offer is accepted this cycle.
REQ-010 Port pwm, output, 1 bit: registered PWM output.
REQ-011 Port period_done, output, 1 bit: registered one-cycle pulse marking a completed PWM period.

Function
REQ-012 State SHALL consist of:
- active duty register (active);
- pending duty register with a full flag;
- pwm flop;
- period_done flop.
REQ-013 duty_ready SHALL equal NOT pending_full, combinationally.
REQ-014 Acceptance SHALL occur on a rising edge where duty_valid and duty_ready are both 1; duty_data is captured at that edge.
REQ-015 An offer with duty_ready = 0 SHALL be ignored; the producer holds duty_data and duty_valid until accepted.
REQ-016 On an edge with wrap = 1 and pending_full = 1:
- active SHALL load the pending value;
- pending_full SHALL clear, so duty_ready is 1 the next cycle.
REQ-017 On an edge with wrap = 1, pending_full = 0 and an acceptance in that cycle, duty_data SHALL bypass the pending slot: it loads directly into active and pending_full stays 0.
REQ-018 On an edge with wrap = 0 and an acceptance, pending_full SHALL set and active SHALL be unchanged.
REQ-019 active SHALL change only on edges with wrap = 1, so a duty change never takes effect mid-period.
REQ-020 On every edge, pwm SHALL load (cnt < active), an unsigned WIDTH-bit compare, giving one cycle of latency from cnt to pwm.
REQ-021 With active = 0, pwm SHALL stay 0 throughout.
REQ-022 With active = 2^WIDTH-1, pwm SHALL be high for 2^WIDTH-1 of every 2^WIDTH cycles.
REQ-023 The compare in the wrap cycle SHALL use the old active value; the new value applies from cnt = 0 onward.
REQ-024 period_done SHALL load wrap on every edge, producing a 1-cycle pulse in the cycle after wrap.
REQ-025 The block SHALL NOT check that cnt and wrap are mutually consistent.

Reset
REQ-026 While RESETN = 0, independent of CLK:
- pwm = 0;
- period_done = 0;
- active = RESET_DUTY;
- pending_full = 0.
REQ-027 duty_ready SHALL read 1 during reset, but no acceptance SHALL occur while RESETN = 0.
REQ-028 A reset asserted mid-period SHALL discard any pending duty, and operation SHALL resume from the first edge after RESETN rises.

Configuration
REQ-029 With macro PWM_STAGE_PERIOD_CNT_EN defined, the block SHALL add port period_cnt (output, 8 bits). period_cnt SHALL:
- reset to 0;
- increment modulo 256 on every edge with wrap = 1.
REQ-030 Without PWM_STAGE_PERIOD_CNT_EN, the port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then run 16 cycles with cnt 0..15 and wrap at 15 -> pwm = 0 throughout, period_done pulses once, duty_ready = 1.
REQ-032 Offer 4 at cnt = 5 -> accepted, duty_ready = 0 until the edge at wrap; next period pwm is high for exactly the 4 cycles following cnt = 0..3.
REQ-033 Offer 9 in the wrap cycle with the pending slot empty -> bypass; in the very next period pwm is high for 9 cycles; duty_ready never drops.
REQ-034 With the pending slot full (7), offer 12 -> not accepted while duty_ready = 0; 7 becomes active at wrap; 12 is accepted the cycle after and becomes active at the following wrap.
REQ-035 Duty 15 -> pwm low only for the cycle following cnt = 15; assert RESETN low at cnt = 8 -> pwm = 0 immediately, pending cleared, active = RESET_DUTY.
REQ-036 With PWM_STAGE_PERIOD_CNT_EN defined, run 257 wraps -> period_cnt = 1; without the macro, the build has no period_cnt port.
